// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: upstream decode bundle and ALU-side operand bundle for the issue stage
interface alu_issue_stage_if #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_aluop;
    logic [5:0]       in_funct;
    logic [WIDTH-1:0] in_rs;
    logic [WIDTH-1:0] in_rt;
    logic [WIDTH-1:0] in_imm;
    logic             in_alusrc;
    logic [RD_W-1:0]  in_rd;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [3:0]       out_op;
    logic [RD_W-1:0]  out_rd;
    logic             out_illegal;
    modport master (
        output in_valid, in_aluop, in_funct, in_rs, in_rt, in_imm, in_alusrc, in_rd, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_op, out_rd, out_illegal
    );
    modport slave (
        input  in_valid, in_aluop, in_funct, in_rs, in_rt, in_imm, in_alusrc, in_rd, out_ready,
        output in_ready, out_valid, out_a, out_b, out_op, out_rd, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes ALUOp/funct, muxes operand B and presents entries to the ALU via a 2-entry skid buffer
module alu_issue_stage #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
) (
    input logic               clk,
    input logic               rst_n,
    input logic               flush,
    alu_issue_stage_if.slave  bus
);
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       op;
        logic [RD_W-1:0]  rd;
        logic             ill;
    } entry_t;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state, state_nx;
    entry_t dec, main_q, skid_q, main_d;
    logic   rdy_q, accept, consume, ld_main, ld_skid;
    assign accept  = bus.in_valid & rdy_q & ~flush;
    assign consume = bus.out_valid & bus.out_ready;
    always_comb begin
        dec.a   = bus.in_rs;
        dec.b   = bus.in_alusrc ? bus.in_imm : bus.in_rt;
        dec.rd  = bus.in_rd;
        dec.op  = 4'b0010;
        dec.ill = 1'b0;
        case (bus.in_aluop)
            2'b00: dec.op = 4'b0010;
            2'b01: dec.op = 4'b0110;
            2'b10: begin
                case (bus.in_funct)
                    6'b100000: dec.op = 4'b0010;
                    6'b100010: dec.op = 4'b0110;
                    6'b100100: dec.op = 4'b0000;
                    6'b100101: dec.op = 4'b0001;
                    6'b101010: dec.op = 4'b0111;
                    6'b100111: dec.op = 4'b1100;
                    default:   dec.ill = 1'b1;
                endcase
            end
            default: dec.ill = 1'b1;
        endcase
    end
    // main is refilled from skid when draining FULL, otherwise from the incoming decode
    always_comb begin
        state_nx = state;
        ld_main  = 1'b0;
        ld_skid  = 1'b0;
        case (state)
            EMPTY: begin
                state_nx = accept ? ONE : EMPTY;
                ld_main  = accept;
            end
            ONE: begin
                state_nx = (accept & ~consume) ? FULL : ((~accept & consume) ? EMPTY : ONE);
                ld_main  = accept & consume;
                ld_skid  = accept & ~consume;
            end
            FULL: begin
                state_nx = consume ? ONE : FULL;
                ld_main  = consume;
            end
            default: state_nx = EMPTY;
        endcase
        if (flush)
            state_nx = EMPTY;
        main_d = (state == FULL) ? skid_q : dec;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= EMPTY;
            rdy_q  <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nx;
            rdy_q <= (state_nx != FULL);
            if (ld_main)
                main_q <= main_d;
            if (ld_skid)
                skid_q <= dec;
        end
    end
    assign bus.in_ready    = rdy_q;
    assign bus.out_valid   = (state != EMPTY);
    assign bus.out_a       = main_q.a;
    assign bus.out_b       = main_q.b;
    assign bus.out_op      = main_q.op;
    assign bus.out_rd      = main_q.rd;
    assign bus.out_illegal = main_q.ill;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: randomized and directed scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;
    localparam int WIDTH = 32;
    localparam int RD_W  = 5;
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       op;
        logic [RD_W-1:0]  rd;
        logic             ill;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic rst_q = 1'b0;
    bit   last_acc;
    int   n_cmp = 0;
    int   n_err = 0;
    int   occ = 0;
    exp_t exp_q[$];
    alu_issue_stage_if #(.WIDTH(WIDTH), .RD_W(RD_W)) bif ();
    alu_issue_stage #(.WIDTH(WIDTH), .RD_W(RD_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bif)
    );
    always #5 clk = ~clk;
    always @(posedge clk) rst_q <= rst_n;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask
    function automatic exp_t ref_model(input logic [1:0] aluop, input logic [5:0] funct,
                                       input logic [WIDTH-1:0] rs, rt, imm,
                                       input logic alusrc, input logic [RD_W-1:0] rd);
        exp_t r;
        r.a   = rs;
        r.b   = alusrc ? imm : rt;
        r.rd  = rd;
        r.ill = 1'b0;
        if (aluop == 2'd0)                     r.op = 4'd2;
        else if (aluop == 2'd1)                r.op = 4'd6;
        else if (aluop == 2'd2 && funct == 32) r.op = 4'd2;
        else if (aluop == 2'd2 && funct == 34) r.op = 4'd6;
        else if (aluop == 2'd2 && funct == 36) r.op = 4'd0;
        else if (aluop == 2'd2 && funct == 37) r.op = 4'd1;
        else if (aluop == 2'd2 && funct == 42) r.op = 4'd7;
        else if (aluop == 2'd2 && funct == 39) r.op = 4'd12;
        else begin
            r.op  = 4'd2;
            r.ill = 1'b1;
        end
        return r;
    endfunction
    task automatic tick();
        bit   acc;
        exp_t e;
        @(negedge clk);
        acc = rst_n && bif.in_valid && bif.in_ready && !flush;
        e = ref_model(bif.in_aluop, bif.in_funct, bif.in_rs, bif.in_rt, bif.in_imm, bif.in_alusrc, bif.in_rd);
        @(posedge clk);
        if (acc)
            exp_q.push_back(e);
        last_acc = acc;
        #1;
    endtask
    task automatic set_in(input logic [1:0] aluop, input logic [5:0] funct, input logic [31:0] rs, rt, imm,
                          input logic alusrc, input logic [4:0] rd);
        bif.in_aluop  = aluop;
        bif.in_funct  = funct;
        bif.in_rs     = rs;
        bif.in_rt     = rt;
        bif.in_imm    = imm;
        bif.in_alusrc = alusrc;
        bif.in_rd     = rd;
        bif.in_valid  = 1'b1;
    endtask
    task automatic wait_acc(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc)
            chk("accept_timeout", 64'(last_acc), 64'd1);
    endtask
    task automatic drain();
        int n = 0;
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 10) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask
    always @(negedge clk) begin
        bit cons, acc;
        exp_t f;
        cons = 1'b0;
        if (!rst_q) begin
            chk("rst_out_valid", 64'(bif.out_valid), 64'd0);
            chk("rst_in_ready", 64'(bif.in_ready), 64'd0);
            chk("rst_outs", {bif.out_a, bif.out_b} | 64'({bif.out_op, bif.out_rd, bif.out_illegal}), 64'd0);
        end else begin
            chk("out_valid", 64'(bif.out_valid), 64'(occ > 0));
            chk("in_ready", 64'(bif.in_ready), 64'(occ < 2));
            if (bif.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'(exp_q.size()), 64'd1);
                end else begin
                    f = exp_q[0];
                    chk("out_a", 64'(bif.out_a), 64'(f.a));
                    chk("out_b", 64'(bif.out_b), 64'(f.b));
                    chk("out_op", 64'(bif.out_op), 64'(f.op));
                    chk("out_rd", 64'(bif.out_rd), 64'(f.rd));
                    chk("out_illegal", 64'(bif.out_illegal), 64'(f.ill));
                    if (bif.out_ready) begin
                        void'(exp_q.pop_front());
                        cons = 1'b1;
                    end
                end
            end
        end
        acc = bif.in_valid && bif.in_ready && !flush;
        if (!rst_n) begin
            occ = 0;
            exp_q.delete();
        end else if (flush) begin
            occ = 0;
            exp_q.delete();
        end else begin
            occ = occ - int'(cons) + int'(acc);
        end
    end
    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
    initial begin
        int n, tot;
        logic [5:0] fl[6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd39};
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b0;
        set_in(2'd0, 6'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        bif.in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 64'(bif.in_ready), 64'd1);
        set_in(2'b10, 6'b100010, 32'hA, 32'h3, 32'h55, 1'b0, 5'd7);
        wait_acc(n);
        bif.in_valid = 1'b0;
        chk("t1_valid", 64'(bif.out_valid), 64'd1);
        chk("t1_op", 64'(bif.out_op), 64'b0110);
        chk("t1_a", 64'(bif.out_a), 64'hA);
        chk("t1_b", 64'(bif.out_b), 64'h3);
        chk("t1_rd", 64'(bif.out_rd), 64'd7);
        chk("t1_ill", 64'(bif.out_illegal), 64'd0);
        bif.out_ready = 1'b1;
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            set_in(2'b00, 6'($urandom), 32'h100 + i, 32'($urandom), 32'hFFFFFFFC - i, 1'b1, 5'(i));
            wait_acc(n);
            tot += n;
            chk("t2_op", 64'(bif.out_op), 64'b0010);
            chk("t2_b", 64'(bif.out_b), 64'hFFFFFFFC - i);
        end
        chk("t2_rate", 64'(tot), 64'd8);
        drain();
        bif.out_ready = 1'b0;
        set_in(2'b01, 6'd0, 32'h11, 32'h1, 32'h0, 1'b0, 5'd1);
        wait_acc(n);
        set_in(2'b01, 6'd0, 32'h22, 32'h2, 32'h0, 1'b0, 5'd2);
        wait_acc(n);
        chk("t3_ready_low", 64'(bif.in_ready), 64'd0);
        set_in(2'b01, 6'd0, 32'h33, 32'h3, 32'h0, 1'b0, 5'd3);
        repeat (3) tick();
        chk("t3_hold_a", 64'(bif.out_a), 64'h11);
        bif.out_ready = 1'b1;
        wait_acc(n);
        drain();
        set_in(2'b10, 6'b000000, 32'h1, 32'h2, 32'h3, 1'b0, 5'd4);
        wait_acc(n);
        chk("t4_ill1", 64'({bif.out_illegal, bif.out_op}), 64'h12);
        set_in(2'b11, 6'b100000, 32'h1, 32'h2, 32'h3, 1'b0, 5'd5);
        wait_acc(n);
        chk("t4_ill2", 64'({bif.out_illegal, bif.out_op}), 64'h12);
        set_in(2'b10, 6'b100111, 32'h1, 32'h2, 32'h3, 1'b0, 5'd6);
        wait_acc(n);
        chk("t4_nor", 64'({bif.out_illegal, bif.out_op}), 64'h0C);
        drain();
        bif.out_ready = 1'b0;
        set_in(2'b00, 6'd0, 32'hA1, 32'h0, 32'h0, 1'b0, 5'd1);
        wait_acc(n);
        set_in(2'b00, 6'd0, 32'hA2, 32'h0, 32'h0, 1'b0, 5'd2);
        wait_acc(n);
        set_in(2'b00, 6'd0, 32'hDEAD, 32'h0, 32'h0, 1'b0, 5'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bif.in_valid = 1'b0;
        chk("t5_valid", 64'(bif.out_valid), 64'd0);
        chk("t5_ready", 64'(bif.in_ready), 64'd1);
        bif.out_ready = 1'b1;
        repeat (3) tick();
        bif.out_ready = 1'b0;
        set_in(2'b00, 6'd0, 32'hB1, 32'h0, 32'h0, 1'b0, 5'd1);
        wait_acc(n);
        set_in(2'b00, 6'd0, 32'hB2, 32'h0, 32'h0, 1'b0, 5'd2);
        wait_acc(n);
        bif.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("t6_valid", 64'(bif.out_valid), 64'd0);
        chk("t6_ready", 64'(bif.in_ready), 64'd0);
        chk("t6_a", 64'(bif.out_a), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_ready_after", 64'(bif.in_ready), 64'd1);
        bif.out_ready = 1'b1;
        repeat (3) tick();
        chk("t6_no_stale", 64'(bif.out_valid), 64'd0);
        for (int i = 0; i < 400; i++) begin
            set_in(2'($urandom), ($urandom_range(0, 2) == 0) ? 6'($urandom) : fl[$urandom_range(0, 5)],
                   32'($urandom), 32'($urandom), 32'($urandom), 1'($urandom), 5'($urandom));
            bif.in_valid  = 1'($urandom);
            bif.out_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 39) == 0);
            tick();
        end
        flush = 1'b0;
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream neighbour of the 32-bit ripple ALU. Accepts decoded instruction fields and register operands over a valid/ready handshake.
- Translates the 2-bit ALUOp plus 6-bit funct into the ALU's 4-bit Op code and selects operand B (register or immediate).
- Presents registered A/B/Op to the ALU through a 2-entry skid buffer. Backpressure therefore never creates a combinational ready path from output to input.

Parameters:
- WIDTH, 32, operand width; must match the ALU datapath width.
- RD_W, 5, destination register tag width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  synchronous pipeline flush; drops all buffered entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept an entry this cycle.
- in_aluop  input  2  ALUOp: 00 = load/store, 01 = branch, 10 = R-type, 11 = reserved.
- in_funct  input  6  R-type funct field.
- in_rs  input  WIDTH  register operand A.
- in_rt  input  WIDTH  register operand B.
- in_imm  input  WIDTH  sign-extended immediate.
- in_alusrc  input  1  1 = operand B is in_imm; 0 = operand B is in_rt.
- in_rd  input  RD_W  destination tag, passed through.
- out_valid  output  1  entry presented to the ALU.
- out_ready  input  1  downstream consumes the entry this cycle.
- out_a  output  WIDTH  ALU operand A.
- out_b  output  WIDTH  ALU operand B after the alusrc mux.
- out_op  output  4  ALU Op code.
- out_rd  output  RD_W  destination tag.
- out_illegal  output  1  decode of this entry was illegal.

Behaviour:
- Handshake
  - A transfer occurs when valid and ready are both high at a rising edge.
  - in_ready is a registered signal: in_ready = 1 exactly when fewer than 2 entries are held.
  - out_valid = 1 exactly when at least 1 entry is held.
  - out_* must hold stable while out_valid=1 and out_ready=0.
- Decode (registered at accept, into 4-bit Op)
  - ALUOp 00 -> 0010 (add).
  - ALUOp 01 -> 0110 (sub).
  - ALUOp 10, funct 100000 -> 0010 (add).
  - ALUOp 10, funct 100010 -> 0110 (sub).
  - ALUOp 10, funct 100100 -> 0000 (and).
  - ALUOp 10, funct 100101 -> 0001 (or).
  - ALUOp 10, funct 101010 -> 0111 (slt).
  - ALUOp 10, funct 100111 -> 1100 (nor).
  - ALUOp 10 with any other funct, or ALUOp 11 -> Op 0010, out_illegal=1.
  - Illegal entries still flow through the handshake; they are not dropped.
- Operand B: in_alusrc=1 selects in_imm; in_alusrc=0 selects in_rt. Selection happens at accept. No width change; all data passes through unmodified.
- Storage
  - Two entries: main (drives out_*) and skid.
  - States: EMPTY (0 entries), ONE (main only), FULL (main + skid).
  - EMPTY + accept -> ONE.
  - ONE + accept, no consume -> FULL.
  - ONE + accept + consume -> ONE; the new entry replaces main.
  - ONE + consume, no accept -> EMPTY.
  - FULL + consume -> ONE; skid moves to main in the same edge.
  - Accept is impossible while FULL because in_ready=0.
- Ordering: strict FIFO. No entry is reordered, duplicated or lost except by flush or reset.
- Flush
  - Next state is EMPTY and in_ready=1.
  - An entry offered in the flush cycle is discarded.
  - A consume in the flush cycle still counts as consumed by downstream.
  - Flush overrides accept.
- Reset (rst_n=0 at an edge)
  - State EMPTY; out_valid=0.
  - out_a, out_b, out_rd = 0; out_op = 0000; out_illegal = 0.
  - in_ready=0 while rst_n=0, and 1 from the first edge after deassertion.
  - Reset asserted mid-transfer discards all entries.
- Latency: 1 cycle from accept to out_valid when EMPTY. Sustained throughput of 1 entry/cycle when out_ready stays high.

Test Plan:
- Reset, then offer aluop=10, funct=100010, rs=0x0000000A, rt=0x00000003, alusrc=0, rd=7 -> next cycle out_valid=1, out_op=0110, out_a=0xA, out_b=0x3, out_rd=7, out_illegal=0.
- Offer aluop=00, alusrc=1, imm=0xFFFFFFFC, rs=0x100 with out_ready=1 -> out_op=0010, out_b=0xFFFFFFFC; back-to-back stream of 8 entries emerges in order at 1 entry/cycle.
- Hold out_ready=0 and offer 3 entries -> in_ready drops after the 2nd accept; out_* stay at entry 1. Raise out_ready -> entries 1, 2, 3 emerge in order with nothing lost.
- Offer aluop=10, funct=000000, then aluop=11 -> both emerge with out_illegal=1 and out_op=0010; the following legal nor (funct=100111) gives out_op=1100, out_illegal=0.
- While FULL, assert flush together with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed-cycle entry never appears at the output.
- Assert rst_n=0 while FULL with out_ready=0 -> all outputs zero, out_valid=0, in_ready=0; after deassertion, in_ready=1 and no stale entry appears.
